// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES chunks, one chunk per register stage.
// Optional subtract support is compiled in with `define RCA_SUB_EN.
module pipelined_rca #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             cin,
`ifdef RCA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = WIDTH / STAGES;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic              ovf_q, ovf_d;
    logic              adv;
    logic [WIDTH-1:0]  b_ent;
    logic              c_ent;

    // Subtraction is folded into the B operand and carry at acceptance, so only operands travel.
`ifdef RCA_SUB_EN
    assign b_ent = sub ? ~in1 : in1;
    assign c_ent = sub ? 1'b1 : cin;
`else
    assign b_ent = in1;
    assign c_ent = cin;
`endif

    assign adv       = !(vld_q[STAGES-1] && !out_ready);
    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];
    assign out       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q;

    always_comb begin
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] s_src;
        logic             c_src;
        logic             v_src;
        logic [CW:0]      tot;
        int               p;

        a_src   = '0;
        b_src   = '0;
        s_src   = '0;
        c_src   = 1'b0;
        v_src   = 1'b0;
        tot     = '0;
        p       = 0;
        vld_d   = vld_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        for (int s = 0; s < STAGES; s++) begin
            a_d[s]   = a_q[s];
            b_d[s]   = b_q[s];
            sum_d[s] = sum_q[s];
        end

        if (adv) begin
            for (int s = 0; s < STAGES; s++) begin
                p     = (s == 0) ? 0 : s - 1;
                a_src = a_q[p];
                b_src = b_q[p];
                s_src = sum_q[p];
                c_src = carry_q[p];
                v_src = vld_q[p];
                if (s == 0) begin
                    a_src = in0;
                    b_src = b_ent;
                    s_src = '0;
                    c_src = c_ent;
                    v_src = in_valid;
                end
                tot = {1'b0, a_src[s*CW +: CW]} + {1'b0, b_src[s*CW +: CW]} + {{CW{1'b0}}, c_src};
                vld_d[s] = v_src;
                // Stage 0 data only loads on a real beat so outputs never pick up undriven operands.
                if (s != 0 || in_valid) begin
                    a_d[s]              = a_src;
                    b_d[s]              = b_src;
                    sum_d[s]            = s_src;
                    sum_d[s][s*CW +: CW] = tot[CW-1:0];
                    carry_d[s]          = tot[CW];
                    if (s == STAGES - 1)
                        ovf_d = tot[CW] ^ (a_src[WIDTH-1] ^ b_src[WIDTH-1] ^ tot[CW-1]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]   <= '0;
                b_q[s]   <= '0;
                sum_q[s] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]   <= a_d[s];
                b_q[s]   <= b_d[s];
                sum_q[s] <= sum_d[s];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: four instances (STAGES 1,2,4,16) share stimulus; each has a result-queue model.
// Directed literal checks target the STAGES=4 instance.
module tb_pipelined_rca;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in0 = '0;
    logic [15:0] in1 = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_ready = 1'b1;

    logic        ir_w  [4];
    logic        ov_w  [4];
    logic [15:0] out_w [4];
    logic        co_w  [4];
    logic        of_w  [4];

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // {ovf, cout, out} from plain arithmetic on the effective operands.
    function automatic logic [17:0] ref_res(input logic [15:0] a, input logic [15:0] b,
                                            input logic c, input logic s);
        logic [15:0] be;
        logic        ce;
        logic [16:0] full;
        be   = s ? ~b : b;
        ce   = s ? 1'b1 : c;
        full = {1'b0, a} + {1'b0, be} + {16'b0, ce};
        return {(a[15] == be[15]) && (full[15] != a[15]), full};
    endfunction

    for (genvar g = 0; g < 4; g++) begin : gi
        localparam int S = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;

        pipelined_rca #(.WIDTH(16), .STAGES(S)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (ir_w[g]),
            .in0       (in0),
            .in1       (in1),
            .cin       (cin),
`ifdef RCA_SUB_EN
            .sub       (sub),
`endif
            .out_valid (ov_w[g]),
            .out_ready (out_ready),
            .out       (out_w[g]),
            .cout      (co_w[g]),
            .ovf       (of_w[g])
        );

        bit          mv [S];
        logic [17:0] mr [S];

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < S; k++) begin
                    mv[k] = 1'b0;
                    mr[k] = '0;
                end
            end else if (!(mv[S-1] && !out_ready)) begin
                for (int k = S - 1; k > 0; k--) begin
                    mv[k] = mv[k-1];
                    mr[k] = mr[k-1];
                end
                mv[0] = in_valid;
                mr[0] = ref_res(in0, in1, cin, sub);
            end
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                chk($sformatf("S%0d rst out_valid", S), 32'(ov_w[g]), 32'd0);
                chk($sformatf("S%0d rst out", S), 32'(out_w[g]), 32'd0);
                chk($sformatf("S%0d rst cout", S), 32'(co_w[g]), 32'd0);
                chk($sformatf("S%0d rst ovf", S), 32'(of_w[g]), 32'd0);
                chk($sformatf("S%0d rst in_ready", S), 32'(ir_w[g]), 32'd1);
            end else begin
                chk($sformatf("S%0d out_valid", S), 32'(ov_w[g]), 32'(mv[S-1]));
                chk($sformatf("S%0d in_ready", S), 32'(ir_w[g]), 32'(!(mv[S-1] && !out_ready)));
                if (mv[S-1])
                    chk($sformatf("S%0d result", S), 32'({of_w[g], co_w[g], out_w[g]}), 32'(mr[S-1]));
            end
        end
    end

    task automatic send_chk(input string nm, input logic [15:0] a, input logic [15:0] b,
                            input logic c, input logic s,
                            input logic [15:0] eo, input logic ec, input logic ev);
        int n;
        in_valid = 1'b1; in0 = a; in1 = b; cin = c; sub = s; out_ready = 1'b1;
        #1;
        chk({nm, " in_ready"}, 32'(ir_w[2]), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!ov_w[2] && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'd3);
        chk({nm, " out"}, 32'(out_w[2]), 32'(eo));
        chk({nm, " cout"}, 32'(co_w[2]), 32'(ec));
        chk({nm, " ovf"}, 32'(of_w[2]), 32'(ev));
    endtask

    initial begin
        int rcv, sent, stalls;
        logic fire_in, fire_out;

        #1 rst_n = 1'b0;
        chk("ref 1234+1",    32'(ref_res(16'h1234, 16'h0001, 1'b0, 1'b0)), 32'h01235);
        chk("ref ffff+0+1",  32'(ref_res(16'hFFFF, 16'h0000, 1'b1, 1'b0)), 32'h10000);
        chk("ref 7fff+1",    32'(ref_res(16'h7FFF, 16'h0001, 1'b0, 1'b0)), 32'h28000);
        chk("ref 5-7",       32'(ref_res(16'h0005, 16'h0007, 1'b0, 1'b1)), 32'h0FFFE);
        chk("ref 8000-1",    32'(ref_res(16'h8000, 16'h0001, 1'b0, 1'b1)), 32'h37FFF);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset asserted mid-stream.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in0 = 16'($urandom); in1 = 16'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 32'(ov_w[2]), 32'd0);
        chk("midrst out",       32'(out_w[2]), 32'd0);
        chk("midrst cout",      32'(co_w[2]), 32'd0);
        chk("midrst ovf",       32'(of_w[2]), 32'd0);
        chk("midrst in_ready",  32'(ir_w[2]), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("post-rst no output", 32'(ov_w[2]), 32'd0);
        end

        send_chk("add 1234+1", 16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0);
        send_chk("ripple ffff", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        send_chk("ovf 7fff+1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`ifdef RCA_SUB_EN
        send_chk("sub 5-7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send_chk("sub 8000-1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif
        sub = 1'b0;

        // Streaming: ten back-to-back beats, results on consecutive cycles.
        for (int it = 0; it < 15; it++) begin
            in_valid = (it < 10); in0 = 16'h0000; in1 = 16'(it); cin = 1'b0; out_ready = 1'b1;
            #1;
            if (it >= 4) begin
                chk("stream valid", 32'(ov_w[2]), 32'(it < 14));
                if (it < 14) chk("stream out", 32'(out_w[2]), 32'(it - 4));
            end
            @(posedge clk); #1;
        end

        // Back-pressure: 5 stall cycles with a full pipe, then release.
        rcv = 0; sent = 0; stalls = 0;
        for (int it = 0; it < 40 && rcv < 6; it++) begin
            in_valid = (sent < 6); in0 = 16'h0000; in1 = 16'h0100 + 16'(sent); cin = 1'b0;
            out_ready = !(it >= 4 && it < 9);
            #1;
            if (ov_w[2] && !out_ready) begin
                stalls++;
                chk("stall hold out", 32'(out_w[2]), 32'(16'h0100 + 16'(rcv)));
                chk("stall in_ready", 32'(ir_w[2]), 32'd0);
            end
            fire_in  = in_valid && ir_w[2];
            fire_out = ov_w[2] && out_ready;
            if (fire_out) begin
                chk("bp order", 32'(out_w[2]), 32'(16'h0100 + 16'(rcv)));
                rcv++;
            end
            @(posedge clk); #1;
            if (fire_in) sent++;
        end
        chk("bp stall cycles", 32'(stalls), 32'd5);
        chk("bp delivered", 32'(rcv), 32'd6);

        in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // Random sweep with random stalls; the per-instance models do the checking.
        for (int it = 0; it < 14000; it++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in0       = 16'($urandom);
            in1       = 16'($urandom);
            cin       = 1'($urandom);
`ifdef RCA_SUB_EN
            sub       = 1'($urandom);
`endif
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end

        in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
